// File: rtl/router_pkg.sv
// Shared router packet layout: default width, field positions,
// terminal FIFO state encodings and destination extraction helpers.
package router_pkg;

    localparam int PCK_SZ_DEF = 40;

    localparam int NXT_HI  = 39;
    localparam int NXT_LO  = 32;
    localparam int ROW_HI  = 31;
    localparam int ROW_LO  = 28;
    localparam int COL_HI  = 27;
    localparam int COL_LO  = 24;
    localparam int MODE_B  = 23;
    localparam int PAY_HI  = 22;
    localparam int PAY_LO  = 0;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    function automatic logic [3:0] dst_row(
        input logic [PCK_SZ_DEF-1:0] pkt
    );
        return pkt[ROW_HI:ROW_LO];
    endfunction

    function automatic logic [3:0] dst_col(
        input logic [PCK_SZ_DEF-1:0] pkt
    );
        return pkt[COL_HI:COL_LO];
    endfunction

endpackage

// File: rtl/router_term_fifo.sv
// Terminal FIFO between an agent and its router port, with an
// occupancy count, sticky overflow flag and a stall watchdog.
// Ports: clk, reset (async active-low), push/din (agent side),
// data_out/pndng/popin (router side), full, count, overflow, stall.
// Optional macro ROUTER_TERM_FIFO_DST_CHECK_EN adds a destination
// range check that drops bad packets and pulses bad_dst.
module router_term_fifo
    import router_pkg::*;
#(
    parameter int PCK_SZ    = PCK_SZ_DEF,
    parameter int DEPTH     = 16,
    parameter int ROWS      = 4,
    parameter int COLUMS    = 4,
    parameter int STALL_LIM = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PCK_SZ-1:0]          din,
    output logic                       full,
    output logic [PCK_SZ-1:0]          data_out,
    output logic                       pndng,
    input  logic                       popin,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef ROUTER_TERM_FIFO_DST_CHECK_EN
    output logic                       bad_dst,
`endif
    output logic                       overflow,
    output logic                       stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(STALL_LIM+1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LIM   = WW'(STALL_LIM);

    logic [PCK_SZ-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [WW-1:0] wd_q,     wd_d;
    logic          ovf_q,    ovf_d;
    logic          stall_q,  stall_d;
    logic [1:0]    state;
    logic          dst_ok;
    logic          do_pop;
    logic          do_wr;

`ifdef ROUTER_TERM_FIFO_DST_CHECK_EN
    localparam logic [3:0] ROWS_L = 4'(ROWS);
    localparam logic [3:0] COLS_L = 4'(COLUMS);

    logic bad_q, bad_d;

    assign dst_ok = (dst_row(din) < ROWS_L) &&
                    (dst_col(din) < COLS_L);
    assign bad_d  = push && !dst_ok;
    assign bad_dst = bad_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bad_q <= 1'b0;
        else        bad_q <= bad_d;
    end
`else
    assign dst_ok = 1'b1;
`endif

    always_comb begin
        state = ST_ACTIVE;
        if (count_q == '0)      state = ST_EMPTY;
        if (count_q == CNT_FULL) state = ST_FULL;
    end

    assign full  = (state == ST_FULL);
    assign pndng = (state != ST_EMPTY);

    // A pop frees the slot in the same edge, so a full FIFO can
    // still accept a write when popin is also asserted.
    assign do_pop = popin && pndng;
    assign do_wr  = push && dst_ok && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr)  wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(do_wr) - CW'(do_pop);
        ovf_d   = ovf_q | (push && dst_ok && full && !popin);
    end

    always_comb begin
        wd_d = '0;
        if (pndng && !popin)
            wd_d = (wd_q == WD_LIM) ? wd_q : wd_q + WW'(1);
        stall_d = stall_q | (wd_d == WD_LIM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wd_q     <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wd_q     <= wd_d;
            ovf_q    <= ovf_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

    // Gate the head so the uninitialised array never shows up.
    assign data_out = pndng ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign stall    = stall_q;

endmodule
